// File: rtl/vpu_operand_fetch.sv
// Operand fetch stage: decodes one VPU instruction, issues bank-conflict-aware SRAM reads
// for its sources, gathers the returned rows and hands one operand bundle to execution.
module vpu_operand_fetch #(
  parameter int RD_LAT  = 1,
  parameter int SRC_CNT = 3,
  parameter int DATA_W  = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic [135:0]              instr_i,
  output logic [SRC_CNT-1:0]        rd_en_o,
  output logic [SRC_CNT*2-1:0]      rd_bank_o,
  output logic [SRC_CNT*10-1:0]     rd_addr_o,
  input  logic [SRC_CNT*DATA_W-1:0] rd_data_i,
  output logic                      op_valid_o,
  input  logic                      op_ready_i,
  output logic [7:0]                opcode_o,
  output logic [1:0]                src_cnt_o,
  output logic [31:0]               dst_addr_o,
  output logic [SRC_CNT*DATA_W-1:0] operand_o,
  output logic                      err_o
);

  localparam int PW = RD_LAT * SRC_CNT;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t                      state, state_nxt;
  logic [SRC_CNT-1:0]          pend, pend_init, grant, emerge;
  logic [3:0]                  used;
  logic [1:0]                  bank [SRC_CNT];
  logic [9:0]                  row  [SRC_CNT];
  logic [7:0]                  opcode_q;
  logic [1:0]                  cnt_q, dec_cnt;
  logic [31:0]                 dst_q;
  logic [SRC_CNT*DATA_W-1:0]   operand_q;
  logic [PW-1:0]               grant_p, pipe_nxt;
  logic                        err_q, accept, legal, drain_done, unused_src_bits;

  function automatic logic [1:0] decode_cnt(input logic [7:0] op);
    case (op)
      8'h06, 8'h07, 8'h11, 8'h12, 8'h1C, 8'h1D, 8'h22: decode_cnt = 2'd1;
      8'h05, 8'h09, 8'h0B, 8'h10, 8'h14, 8'h16, 8'h1B, 8'h1F, 8'h21: decode_cnt = 2'd3;
      default: decode_cnt = (op >= 8'h01 && op <= 8'h21) ? 2'd2 : 2'd0;
    endcase
  endfunction

  assign dec_cnt = decode_cnt(instr_i[135:128]);
  assign legal   = (dec_cnt != 2'd0);
  assign accept  = instr_valid_i && (state == IDLE);

  always_comb begin
    pend_init       = '0;
    unused_src_bits = 1'b0;
    for (int i = 0; i < SRC_CNT; i++) begin
      pend_init[i]    = (i < int'(dec_cnt));
      unused_src_bits = unused_src_bits ^ (^{instr_i[32*(i+1)+21 +: 11], instr_i[32*(i+1) +: 9]});
    end
  end

  // Lowest pending source always wins; others join only on a bank not yet claimed this cycle.
  always_comb begin
    grant = '0;
    used  = '0;
    if (state == ISSUE) begin
      for (int i = 0; i < SRC_CNT; i++) begin
        if (pend[i] && !used[bank[i]]) begin
          grant[i]      = 1'b1;
          used[bank[i]] = 1'b1;
        end
      end
    end
  end

  // Grant masks ride a RD_LAT-deep shift line; the oldest stage marks the rows arriving now.
  always_comb begin
    pipe_nxt              = grant_p << SRC_CNT;
    pipe_nxt[SRC_CNT-1:0] = grant;
  end

  assign emerge     = grant_p[PW-1 -: SRC_CNT];
  assign drain_done = (pipe_nxt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && legal)              state_nxt = ISSUE;
      ISSUE:   if ((pend & ~grant) == '0)        state_nxt = DRAIN;
      DRAIN:   if (drain_done)                   state_nxt = OUT;
      OUT:     if (op_ready_i)                   state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready_o = (state == IDLE);
    op_valid_o    = (state == OUT);
    rd_en_o       = grant;
    rd_bank_o     = '0;
    rd_addr_o     = '0;
    if (state != IDLE) begin
      for (int i = 0; i < SRC_CNT; i++) begin
        rd_bank_o[i*2 +: 2]  = bank[i];
        rd_addr_o[i*10 +: 10] = row[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      grant_p   <= '0;
      opcode_q  <= '0;
      cnt_q     <= '0;
      dst_q     <= '0;
      operand_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < SRC_CNT; i++) begin
        bank[i] <= '0;
        row[i]  <= '0;
      end
    end else begin
      err_q   <= accept && !legal;
      grant_p <= pipe_nxt;
      if (accept && legal) begin
        pend      <= pend_init;
        opcode_q  <= instr_i[135:128];
        cnt_q     <= dec_cnt;
        dst_q     <= instr_i[31:0];
        operand_q <= '0;
        for (int i = 0; i < SRC_CNT; i++) begin
          bank[i] <= instr_i[32*(i+1)+9 +: 2];
          row[i]  <= instr_i[32*(i+1)+11 +: 10];
        end
      end else begin
        pend <= pend & ~grant;
      end
      for (int i = 0; i < SRC_CNT; i++) begin
        if (emerge[i]) operand_q[i*DATA_W +: DATA_W] <= rd_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign opcode_o   = opcode_q;
  assign src_cnt_o  = cnt_q;
  assign dst_addr_o = dst_q;
  assign operand_o  = operand_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_vpu_operand_fetch.sv
// Bench for vpu_operand_fetch: two instances (read latency 1 and 4) behind a selector,
// each fed by a latency-matched SRAM responder, checked against a transaction-level model.
module tb_vpu_operand_fetch;
  localparam int DW = 512;
  localparam int NS = 3;
  localparam logic [7:0] ONE_OPS   [7] = '{8'h06, 8'h07, 8'h11, 8'h12, 8'h1C, 8'h1D, 8'h22};
  localparam logic [7:0] THREE_OPS [9] = '{8'h05, 8'h09, 8'h0B, 8'h10, 8'h14, 8'h16, 8'h1B, 8'h1F, 8'h21};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  int           sel = 0;
  logic         instr_valid = 1'b0;
  logic [135:0] instr = '0;
  logic         op_ready = 1'b0;
  int           n_vec = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_row(input logic [1:0] b, input logic [9:0] r);
    logic [DW-1:0] v;
    logic [31:0]   w;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      w = ({16'h0, b, r, 4'(k)} + 32'h1234_5678) * 32'h9E37_79B1;
      v[k*32 +: 32] = w;
    end
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 4;
    logic              ready, op_valid, err;
    logic [NS-1:0]     rd_en;
    logic [2*NS-1:0]   rd_bank;
    logic [10*NS-1:0]  rd_addr;
    logic [NS*DW-1:0]  rd_data, operand;
    logic [7:0]        opcode;
    logic [1:0]        src_cnt;
    logic [31:0]       dst;
    logic [NS-1:0]     en_d   [LAT];
    logic [2*NS-1:0]   bank_d [LAT];
    logic [10*NS-1:0]  addr_d [LAT];
    logic [31:0]       junk;

    vpu_operand_fetch #(.RD_LAT(LAT), .SRC_CNT(NS), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .instr_valid_i(instr_valid && (sel == g)), .instr_ready_o(ready), .instr_i(instr),
      .rd_en_o(rd_en), .rd_bank_o(rd_bank), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
      .op_valid_o(op_valid), .op_ready_i(op_ready && (sel == g)),
      .opcode_o(opcode), .src_cnt_o(src_cnt), .dst_addr_o(dst), .operand_o(operand),
      .err_o(err)
    );

    always @(posedge clk) begin
      en_d[0]   <= rd_en;
      bank_d[0] <= rd_bank;
      addr_d[0] <= rd_addr;
      for (int j = 1; j < LAT; j++) begin
        en_d[j]   <= en_d[j-1];
        bank_d[j] <= bank_d[j-1];
        addr_d[j] <= addr_d[j-1];
      end
      junk <= $urandom;
    end

    always_comb begin
      rd_data = '0;
      for (int i = 0; i < NS; i++) begin
        rd_data[i*DW +: DW] = en_d[LAT-1][i] ?
          mem_row(bank_d[LAT-1][i*2 +: 2], addr_d[LAT-1][i*10 +: 10]) : {16{junk ^ 32'(i)}};
      end
    end
  end

  logic             m_ready, m_op_valid, m_err;
  logic [NS-1:0]    m_rd_en;
  logic [2*NS-1:0]  m_rd_bank;
  logic [10*NS-1:0] m_rd_addr;
  logic [NS*DW-1:0] m_operand;
  logic [7:0]       m_opcode;
  logic [1:0]       m_src_cnt;
  logic [31:0]      m_dst;
  int               lat;

  assign m_ready    = (sel == 1) ? g_dut[1].ready    : g_dut[0].ready;
  assign m_op_valid = (sel == 1) ? g_dut[1].op_valid : g_dut[0].op_valid;
  assign m_err      = (sel == 1) ? g_dut[1].err      : g_dut[0].err;
  assign m_rd_en    = (sel == 1) ? g_dut[1].rd_en    : g_dut[0].rd_en;
  assign m_rd_bank  = (sel == 1) ? g_dut[1].rd_bank  : g_dut[0].rd_bank;
  assign m_rd_addr  = (sel == 1) ? g_dut[1].rd_addr  : g_dut[0].rd_addr;
  assign m_operand  = (sel == 1) ? g_dut[1].operand  : g_dut[0].operand;
  assign m_opcode   = (sel == 1) ? g_dut[1].opcode   : g_dut[0].opcode;
  assign m_src_cnt  = (sel == 1) ? g_dut[1].src_cnt  : g_dut[0].src_cnt;
  assign m_dst      = (sel == 1) ? g_dut[1].dst      : g_dut[0].dst;
  assign lat        = (sel == 1) ? 4 : 1;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_cnt(input logic [7:0] op);
    if (op == 8'h00 || op > 8'h22) return 0;
    foreach (ONE_OPS[i])   if (ONE_OPS[i] == op)   return 1;
    foreach (THREE_OPS[i]) if (THREE_OPS[i] == op) return 3;
    return 2;
  endfunction

  function automatic logic [31:0] mk_src(input logic [1:0] b, input logic [9:0] r);
    logic [31:0] x;
    x = $urandom;
    x[10:9]  = b;
    x[20:11] = r;
    return x;
  endfunction

  task automatic chk_cleared(input string tag);
    chk({tag, "_rd_en"},    m_rd_en, 0);
    chk({tag, "_op_valid"}, m_op_valid, 0);
    chk({tag, "_err"},      m_err, 0);
    chk({tag, "_bank"},     m_rd_bank, 0);
    chk({tag, "_addr"},     m_rd_addr, 0);
    chk({tag, "_opcode"},   m_opcode, 0);
    chk({tag, "_cnt"},      m_src_cnt, 0);
    chk({tag, "_dst"},      m_dst, 0);
    for (int i = 0; i < NS; i++) chk({tag, "_slot"}, m_operand[i*DW +: DW], 0);
  endtask

  // Drives one instruction from a negedge in IDLE and follows it to the end of its OUT handshake.
  task automatic run_instr(input logic [7:0] op, input logic [31:0] s0, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] d, input int hold);
    logic [31:0] s [3];
    logic [1:0]  bk [3];
    logic [9:0]  rw [3];
    logic [2:0]  rounds [4];
    logic [2:0]  rem, m;
    logic [3:0]  used;
    int          cnt, nr, c;
    bit          done;
    s   = '{s0, s1, s2};
    cnt = exp_cnt(op);
    for (int i = 0; i < 3; i++) begin
      bk[i] = s[i][10:9];
      rw[i] = s[i][20:11];
    end
    chk("idle_ready", m_ready, 1);
    instr       = {op, s2, s1, s0, d};
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    if (cnt == 0) begin
      chk("err_pulse", m_err, 1);
      chk("err_ready", m_ready, 1);
      chk("err_rd_en", m_rd_en, 0);
      @(negedge clk);
      chk("err_clear", m_err, 0);
      chk("err_noread", m_rd_en, 0);
      return;
    end
    rem = '0;
    for (int i = 0; i < cnt; i++) rem[i] = 1'b1;
    nr = 0;
    while (rem != 0 && nr < 4) begin
      used = '0;
      m    = '0;
      for (int i = 0; i < 3; i++) begin
        if (rem[i] && !used[bk[i]]) begin
          m[i]        = 1'b1;
          used[bk[i]] = 1'b1;
        end
      end
      rounds[nr] = m;
      nr++;
      rem = rem & ~m;
    end
    c    = 1;
    done = 0;
    while (!done) begin
      chk("rd_en", m_rd_en, (c <= nr) ? rounds[c-1] : 3'b000);
      for (int i = 0; i < 3; i++) begin
        if (c <= nr && rounds[c-1][i]) begin
          chk("rd_bank", m_rd_bank[i*2 +: 2], bk[i]);
          chk("rd_addr", m_rd_addr[i*10 +: 10], rw[i]);
        end
      end
      if (m_op_valid) begin
        chk("latency", c, nr + 1 + lat);
        done = 1;
      end else if (c >= 40) begin
        chk("timeout_op_valid", 0, 1);
        return;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("op_valid", m_op_valid, 1);
      chk("busy_ready", m_ready, 0);
      chk("opcode", m_opcode, op);
      chk("src_cnt", m_src_cnt, cnt);
      chk("dst", m_dst, d);
      for (int i = 0; i < 3; i++)
        chk("operand", m_operand[i*DW +: DW], (i < cnt) ? mem_row(bk[i], rw[i]) : '0);
    end
    op_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_ready = 1'b0;
    chk("out_done_valid", m_op_valid, 0);
    chk("out_done_ready", m_ready, 1);
  endtask

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++) begin
      run_instr(8'($urandom_range(0, 37)),
                mk_src(2'($urandom), 10'($urandom)), mk_src(2'($urandom), 10'($urandom)),
                mk_src(2'($urandom), 10'($urandom)), $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk_cleared("in_reset");
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", m_ready, 1);
    chk_cleared("post_reset");

    run_instr(8'h17, 32'h0000_2800, 32'h0000_2A00, mk_src(2'd3, 10'd77), 32'hDEAD_0001, 0);
    run_instr(8'h10, mk_src(2'd2, 10'd1), mk_src(2'd2, 10'd2), mk_src(2'd2, 10'd3), 32'hDEAD_0002, 1);
    run_instr(8'h1C, 32'h0000_0600, mk_src(2'd1, 10'd9), mk_src(2'd2, 10'd9), 32'hDEAD_0003, 0);
    run_instr(8'h00, mk_src(2'd0, 10'd4), mk_src(2'd1, 10'd4), mk_src(2'd2, 10'd4), 32'h0, 0);
    run_instr(8'h23, mk_src(2'd0, 10'd4), mk_src(2'd1, 10'd4), mk_src(2'd2, 10'd4), 32'h0, 0);
    run_instr(8'h05, mk_src(2'd0, 10'd11), mk_src(2'd0, 10'd12), mk_src(2'd3, 10'd13), 32'hDEAD_0004, 0);
    run_instr(8'h19, mk_src(2'd1, 10'd1023), mk_src(2'd3, 10'd512), mk_src(2'd0, 10'd0), 32'hDEAD_0005, 10);

    // Reset in the middle of a three-round issue, while the first row is on its way back.
    instr       = {8'h10, mk_src(2'd2, 10'd30), mk_src(2'd2, 10'd31), mk_src(2'd2, 10'd32), 32'hBEEF_0000};
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("rst_case_round1", m_rd_en, 3'b001);
    @(negedge clk);
    chk("rst_case_round2", m_rd_en, 3'b010);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", m_ready, 1);
    chk_cleared("mid_rst");
    repeat (3) @(negedge clk);
    chk_cleared("held_rst");
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_ready", m_ready, 1);
    chk_cleared("after_rst");
    run_instr(8'h10, mk_src(2'd2, 10'd40), mk_src(2'd2, 10'd41), mk_src(2'd2, 10'd42), 32'hBEEF_0001, 0);

    run_random(40);

    sel = 1;
    @(negedge clk);
    run_instr(8'h1C, 32'h0000_0600, mk_src(2'd1, 10'd5), mk_src(2'd2, 10'd6), 32'hCAFE_0001, 0);
    run_instr(8'h14, mk_src(2'd3, 10'd7), mk_src(2'd3, 10'd8), mk_src(2'd1, 10'd9), 32'hCAFE_0002, 2);
    run_random(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/vpu_operand_fetch.md
# vpu_operand_fetch

Decode-and-fetch stage between the VPU request FIFO and the vector lanes. It pops one 136-bit instruction, decodes the opcode into a source-operand count, and issues SRAM bank reads for each source. Reads are serialised only where sources collide on a bank. It collects the 512-bit rows and presents one operand bundle, with opcode and destination address, to the execution stage over a valid/ready handshake.

## Interface
- RD_LAT, 1, SRAM read latency in cycles; legal 1..4.
- SRC_CNT, 3, number of read ports; port i always serves src i.
- DATA_W, 512, SRAM row width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid_i  in  1  instruction available from request FIFO.
- instr_ready_o  out  1  block accepts instruction; high only in IDLE.
- instr_i  in  136  {opcode[135:128], src2[127:96], src1[95:64], src0[63:32], dst0[31:0]}.
- rd_en_o  out  3  per-port read strobe.
- rd_bank_o  out  3x2  per-port bank id = srcN[10:9].
- rd_addr_o  out  3x10  per-port row = srcN[20:11].
- rd_data_i  in  3x512  per-port read data, valid RD_LAT cycles after the matching rd_en_o cycle.
- op_valid_o  out  1  operand bundle valid.
- op_ready_i  in  1  execution stage accepts bundle.
- opcode_o  out  8  latched opcode.
- src_cnt_o  out  2  number of valid operands (1..3).
- dst_addr_o  out  32  latched dst0.
- operand_o  out  3x512  operand i in bits [i*512 +: 512]; unused slots zero.
- err_o  out  1  one-cycle pulse on illegal opcode.

## Operation
- Decode src_cnt:
  - 1 for UISUM 0x06, UIMAX 0x07, ISUM 0x11, IMAX 0x12, FSUM 0x1C, FMAX 0x1D, FEXP 0x22.
  - 3 for UIADD3 0x05, UIMAX3 0x09, UIAVG3 0x0B, IADD3 0x10, IMAX3 0x14, IAVG3 0x16, FADD3 0x1B, FMAX3 0x1F, FAVG3 0x21.
  - 2 for all other opcodes in 0x01..0x21.
  - 0x00 and 0x23..0xFF are illegal.
- FSM states IDLE, ISSUE, DRAIN, OUT.
  - IDLE: instr_ready_o=1. On handshake with a legal opcode: latch instr; set pending mask P to the low src_cnt bits; clear operand regs; go to ISSUE. On handshake with an illegal opcode: err_o=1 next cycle, instruction dropped, stay IDLE.
  - ISSUE: grant the lowest-index pending source. Also grant each other pending source whose bank differs from every source already granted this cycle (scan in index order). rd_en_o = grant mask; clear granted bits from P. When P becomes empty, go to DRAIN.
  - DRAIN: a RD_LAT-deep shift pipeline of grant masks marks returning data. rd_data_i[i] is captured into operand reg i in the cycle its pipeline bit emerges. When the pipeline is empty after capture, go to OUT.
  - OUT: op_valid_o=1 and outputs held stable until op_ready_i=1. Then go to IDLE.
- Bits [31:21] and [8:0] of source addresses are ignored.
- rd_bank_o/rd_addr_o are driven from latched sources whenever the state is not IDLE; they are 0 in IDLE.

## Timing
- Reset: state=IDLE. instr_ready_o=1 after reset release. rd_en_o, op_valid_o and err_o are 0. All data outputs are 0. Grant pipeline is cleared; returning read data after reset is ignored.
- Handshake accepted at edge ending cycle T. rd_en_o asserts in T+1. Data arrives in T+1+RD_LAT. op_valid_o rises in T+2+RD_LAT when there is no bank conflict. Each extra issue round adds 1 cycle.
- No overlap: the next instruction is accepted no earlier than the cycle after the OUT handshake.
- op_valid_o never drops without op_ready_i. Outputs are constant while op_valid_o=1 and op_ready_i=0.
- err_o is high exactly one cycle. instr_ready_o stays high through the error cycle.
- Reset asserted in any state returns all outputs to reset values immediately (asynchronous).

## Test plan
- RD_LAT=1, FADD 0x17, src0=0x00002800 (bank0,row5), src1=0x00002A00 (bank1,row5) -> rd_en_o=011 in T+1, rd_addr=5/5, bank 0/1. op_valid_o at T+3 with src_cnt_o=2 and operand slot 2 zero.
- IADD3 0x10, all three sources in bank 2 -> rd_en_o = 001, 010, 100 in T+1..T+3; op_valid_o at T+5; src_cnt_o=3; operands match per-port data.
- FSUM 0x1C, src0=0x00000600 (bank3,row0) -> only rd_en_o[0] pulses; src_cnt_o=1; slots 1,2 zero. Repeat with RD_LAT=4 -> op_valid_o at T+6.
- Opcodes 0x00 and 0x23 -> err_o one-cycle pulse each; no rd_en_o; instr_ready_o stays 1; next legal instruction is processed normally.
- FMUL 0x19 with op_ready_i low for 10 cycles -> op_valid_o, operand_o and dst_addr_o stable; instr_ready_o=0. Release op_ready_i -> IDLE next cycle.
- Assert rst while in ISSUE of a 3-src conflict case -> outputs zero immediately. Returning rd_data_i is not captured. After release, instr_ready_o=1 and the next instruction completes correctly.
